// File: rtl/sdr_modport_checker.sv
// -----------------------------------------------------------------------------
// sdr_modport_checker
//
// Passive SDRAM command-bus protocol checker. Each rising edge of sdram_clk it
// decodes {cs_n,ras_n,cas_n,we_n}, advances a state machine for each of the
// four banks, and reports protocol violations. It drives nothing on the bus.
//
// Parameters (all in sdram_clk cycles):
//   BURST_LENGTH  read/write burst length
//   TRAS          minimum ACTIVE -> PRECHARGE spacing
//   TRCD          minimum ACTIVE -> READ/WRITE spacing
//   TRP           minimum PRECHARGE -> next bank command spacing
//   TWR           minimum WRITE -> PRECHARGE spacing
//
// Ports:
//   sdram_clk      in   clock, rising edge
//   sdram_resetn   in   synchronous active-low reset
//   sdr_init_done  in   controller init sequence complete
//   sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n   in   command pins
//   sdr_ba         in   [1:0]  bank address
//   sdr_addr       in   [12:0] address; bit 10 = auto-precharge / precharge-all
//   bank_state     out  [15:0] 4-bit state per bank, bank0 in [3:0]
//   cmd_err        out  same-bank illegal command seen last cycle
//   xbank_err      out  cross-bank illegal command seen last cycle
//   timing_err     out  [3:0] {twr,trp,trcd,tras} violation seen last cycle
//   fail_count     out  [31:0] saturating count of offending banks
// -----------------------------------------------------------------------------
module sdr_modport_checker #(
  parameter int BURST_LENGTH = 1,
  parameter int TRAS         = 1,
  parameter int TRCD         = 1,
  parameter int TRP          = 1,
  parameter int TWR          = 1
) (
  input  logic        sdram_clk,
  input  logic        sdram_resetn,
  input  logic        sdr_init_done,
  input  logic        sdr_cs_n,
  input  logic        sdr_ras_n,
  input  logic        sdr_cas_n,
  input  logic        sdr_we_n,
  input  logic [1:0]  sdr_ba,
  input  logic [12:0] sdr_addr,
  output logic [15:0] bank_state,
  output logic        cmd_err,
  output logic        xbank_err,
  output logic [3:0]  timing_err,
  output logic [31:0] fail_count
);

  localparam int NB = 4;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_BST, CMD_PRE, CMD_REF, CMD_LMR
  } cmd_e;

  typedef enum logic [3:0] {
    ST_INIT        = 4'd0,
    ST_IDLE        = 4'd1,
    ST_REFRESHING  = 4'd2,
    ST_ACTIVATING  = 4'd3,
    ST_ACTIVE      = 4'd4,
    ST_RD          = 4'd5,
    ST_RD_W_PC     = 4'd6,
    ST_WR          = 4'd7,
    ST_WR_W_PC     = 4'd8,
    ST_PRECHARGING = 4'd9
  } bank_state_e;

  // N-1 clamped at zero: used both as the dwell exit threshold and as the
  // timing-window reload value. N<=1 gives a 1-cycle dwell / disabled window.
  function automatic logic [31:0] last_cycle(input int n);
    return (n > 1) ? 32'(n - 1) : 32'd0;
  endfunction

  localparam logic [31:0] BL_LAST   = last_cycle(BURST_LENGTH);
  localparam logic [31:0] TRAS_LAST = last_cycle(TRAS);
  localparam logic [31:0] TRCD_LAST = last_cycle(TRCD);
  localparam logic [31:0] TRP_LAST  = last_cycle(TRP);
  localparam logic [31:0] TWR_LAST  = last_cycle(TWR);

  function automatic logic is_timed(input bank_state_e s);
    return s inside {ST_REFRESHING, ST_ACTIVATING, ST_RD, ST_WR,
                     ST_RD_W_PC, ST_WR_W_PC, ST_PRECHARGING};
  endfunction

  function automatic logic cmd_legal(input bank_state_e s, input cmd_e c);
    logic ok;
    case (s)
      ST_IDLE:      ok = c inside {CMD_NOP, CMD_ACT, CMD_REF, CMD_LMR, CMD_PRE};
      ST_ACTIVE:    ok = c inside {CMD_NOP, CMD_RD, CMD_WR, CMD_PRE};
      ST_RD, ST_WR: ok = c inside {CMD_NOP, CMD_RD, CMD_WR, CMD_PRE, CMD_BST};
      default:      ok = (c == CMD_NOP);
    endcase
    return ok;
  endfunction

  // Open timing window: reload on trigger, otherwise count down to zero.
  function automatic logic [31:0] window_next(input logic [31:0] q,
                                              input logic        load,
                                              input logic [31:0] reload);
    if (load)           return reload;
    else if (q != '0)   return q - 32'd1;
    else                return '0;
  endfunction

  cmd_e          cmd;
  logic          a10;
  logic          unused_addr;

  bank_state_e   state_q [NB];
  bank_state_e   state_d [NB];
  logic [31:0]   dwell_q [NB];
  logic [31:0]   dwell_d [NB];
  logic [31:0]   tras_q  [NB];
  logic [31:0]   tras_d  [NB];
  logic [31:0]   trcd_q  [NB];
  logic [31:0]   trcd_d  [NB];
  logic [31:0]   trp_q   [NB];
  logic [31:0]   trp_d   [NB];
  logic [31:0]   twr_q   [NB];
  logic [31:0]   twr_d   [NB];

  logic [NB-1:0] targeted;
  logic [NB-1:0] ba_hit;
  logic [NB-1:0] restart;
  logic [NB-1:0] illegal;
  logic [NB-1:0] busy;
  logic [NB-1:0] v_tras, v_trcd, v_trp, v_twr;
  logic          xbank;
  logic [2:0]    n_illegal;
  logic [32:0]   fc_sum;
  logic [31:0]   fc_next;

  assign a10         = sdr_addr[10];
  assign unused_addr = ^{sdr_addr[12:11], sdr_addr[9:0]};

  // ---------------------------------------------------------------------------
  // Command decode. A deselected bus (cs_n=1) is a NOP whatever the other pins.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cmd = CMD_NOP;
    if (!sdr_cs_n) begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b110:  cmd = CMD_BST;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_LMR;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bank next state and dwell counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    targeted = '0;
    ba_hit   = '0;
    restart  = '0;
    for (int i = 0; i < NB; i++) begin
      ba_hit[i]   = (sdr_ba == 2'(i));
      // PRECHARGE with A10 set is "precharge all" and hits every bank.
      targeted[i] = ba_hit[i] || (cmd == CMD_PRE && a10);
      state_d[i]  = state_q[i];

      case (state_q[i])
        ST_INIT: begin
          if (sdr_init_done) state_d[i] = ST_IDLE;
        end
        ST_IDLE: begin
          if (targeted[i] && cmd == CMD_ACT)      state_d[i] = ST_ACTIVATING;
          else if (targeted[i] && cmd == CMD_REF) state_d[i] = ST_REFRESHING;
        end
        ST_REFRESHING: state_d[i] = ST_IDLE;
        ST_ACTIVATING: begin
          if (dwell_q[i] >= TRCD_LAST) state_d[i] = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (targeted[i]) begin
            case (cmd)
              CMD_WR:  state_d[i] = a10 ? ST_WR_W_PC : ST_WR;
              CMD_RD:  state_d[i] = a10 ? ST_RD_W_PC : ST_RD;
              CMD_PRE: state_d[i] = ST_PRECHARGING;
              default: state_d[i] = ST_ACTIVE;
            endcase
          end
        end
        ST_RD, ST_WR: begin
          // A new burst command wins over burst completion in the same cycle;
          // re-issuing the same burst type restarts the burst timer.
          if (targeted[i] && cmd == CMD_WR) begin
            state_d[i] = ST_WR;
            restart[i] = 1'b1;
          end else if (targeted[i] && cmd == CMD_RD) begin
            state_d[i] = ST_RD;
            restart[i] = 1'b1;
          end else if (targeted[i] && cmd == CMD_PRE) begin
            state_d[i] = ST_PRECHARGING;
          end else if (targeted[i] && cmd == CMD_BST) begin
            state_d[i] = ST_ACTIVE;
          end else if (dwell_q[i] >= BL_LAST) begin
            state_d[i] = ST_ACTIVE;
          end
        end
        ST_RD_W_PC, ST_WR_W_PC: begin
          if (dwell_q[i] >= BL_LAST) state_d[i] = ST_PRECHARGING;
        end
        ST_PRECHARGING: begin
          if (dwell_q[i] >= TRP_LAST) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_INIT;
      endcase

      if (state_d[i] != state_q[i] || restart[i]) dwell_d[i] = '0;
      else if (is_timed(state_q[i]))              dwell_d[i] = dwell_q[i] + 32'd1;
      else                                        dwell_d[i] = dwell_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Same-bank and cross-bank legality.
  // ---------------------------------------------------------------------------
  always_comb begin
    illegal   = '0;
    busy      = '0;
    xbank     = 1'b0;
    n_illegal = '0;
    for (int i = 0; i < NB; i++) begin
      illegal[i] = targeted[i] && (state_q[i] != ST_INIT) &&
                   !cmd_legal(state_q[i], cmd);
      busy[i]    = (state_q[i] >= ST_ACTIVATING) && (state_q[i] <= ST_PRECHARGING);
      n_illegal  = n_illegal + {2'b00, illegal[i]};
    end
    // Only REF and LMR are forbidden while another bank has a row in flight.
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < NB; j++) begin
        if (i != j && busy[i] && targeted[j] && (cmd == CMD_REF || cmd == CMD_LMR))
          xbank = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timing windows: a non-zero counter means the window is still open.
  // ---------------------------------------------------------------------------
  always_comb begin
    v_tras = '0;
    v_trcd = '0;
    v_trp  = '0;
    v_twr  = '0;
    for (int i = 0; i < NB; i++) begin
      v_tras[i] = (cmd == CMD_PRE) && targeted[i] && (tras_q[i] != '0);
      v_trcd[i] = (cmd == CMD_RD || cmd == CMD_WR) && ba_hit[i] && (trcd_q[i] != '0);
      v_trp[i]  = (cmd != CMD_NOP) && ba_hit[i] && (trp_q[i] != '0);
      v_twr[i]  = (cmd == CMD_PRE) && targeted[i] && (twr_q[i] != '0);

      tras_d[i] = window_next(tras_q[i], cmd == CMD_ACT && ba_hit[i], TRAS_LAST);
      trcd_d[i] = window_next(trcd_q[i], cmd == CMD_ACT && ba_hit[i], TRCD_LAST);
      // A precharge of a bank that is already idle does not start a tRP window.
      trp_d[i]  = window_next(trp_q[i],
                              cmd == CMD_PRE && targeted[i] && state_q[i] != ST_IDLE,
                              TRP_LAST);
      twr_d[i]  = window_next(twr_q[i], cmd == CMD_WR && ba_hit[i], TWR_LAST);
    end
  end

  always_comb begin
    fc_sum  = {1'b0, fail_count} + 33'(n_illegal);
    fc_next = fc_sum[32] ? '1 : fc_sum[31:0];
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= ST_INIT;
        dwell_q[i] <= '0;
        tras_q[i]  <= '0;
        trcd_q[i]  <= '0;
        trp_q[i]   <= '0;
        twr_q[i]   <= '0;
      end
      cmd_err    <= 1'b0;
      xbank_err  <= 1'b0;
      timing_err <= '0;
      fail_count <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        dwell_q[i] <= dwell_d[i];
        tras_q[i]  <= tras_d[i];
        trcd_q[i]  <= trcd_d[i];
        trp_q[i]   <= trp_d[i];
        twr_q[i]   <= twr_d[i];
      end
      cmd_err    <= |illegal;
      xbank_err  <= xbank;
      timing_err <= {|v_twr, |v_trp, |v_trcd, |v_tras};
      fail_count <= fc_next;
    end
  end

  assign bank_state = {state_q[3], state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_sdr_modport_checker.sv
// -----------------------------------------------------------------------------
// tb_sdr_modport_checker
//
// Directed bench for sdr_modport_checker with BURST_LENGTH=4, TRAS=4, TRCD=3,
// TRP=2, TWR=2. Each step drives one command on the falling edge, queues the
// outputs expected after the next rising edge, then pops and compares them.
// -----------------------------------------------------------------------------
module tb_sdr_modport_checker;

  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0001;
  localparam logic [3:0] P_DES = 4'b1011;  // cs_n high, ACT pattern on the rest

  logic        clk = 1'b0;
  logic        resetn;
  logic        init_done;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [15:0] bank_state;
  logic        cmd_err;
  logic        xbank_err;
  logic [3:0]  timing_err;
  logic [31:0] fail_count;

  typedef struct {
    logic [15:0] st;
    logic        ce;
    logic        xe;
    logic [3:0]  te;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  sdr_modport_checker #(
    .BURST_LENGTH(4),
    .TRAS        (4),
    .TRCD        (3),
    .TRP         (2),
    .TWR         (2)
  ) dut (
    .sdram_clk    (clk),
    .sdram_resetn (resetn),
    .sdr_init_done(init_done),
    .sdr_cs_n     (cs_n),
    .sdr_ras_n    (ras_n),
    .sdr_cas_n    (cas_n),
    .sdr_we_n     (we_n),
    .sdr_ba       (ba),
    .sdr_addr     (addr),
    .bank_state   (bank_state),
    .cmd_err      (cmd_err),
    .xbank_err    (xbank_err),
    .timing_err   (timing_err),
    .fail_count   (fail_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req)
    else begin
      errors++;
      $error("FAIL step%0d %s: observed %0h expected %0h", step_no, tag, obs, req);
    end
  endtask

  task automatic step(input logic rn, input logic id, input logic [3:0] pins,
                      input logic [1:0] bank, input logic a10,
                      input logic [15:0] st, input logic ce, input logic xe,
                      input logic [3:0] te, input logic [31:0] fc);
    exp_t e;
    exp_t got;
    @(negedge clk);
    resetn    = rn;
    init_done = id;
    {cs_n, ras_n, cas_n, we_n} = pins;
    ba        = bank;
    addr      = 13'($urandom);
    addr[10]  = a10;
    e.st = st; e.ce = ce; e.xe = xe; e.te = te; e.fc = fc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("bank_state", 32'(bank_state), 32'(got.st));
    check("cmd_err",    32'(cmd_err),    32'(got.ce));
    check("xbank_err",  32'(xbank_err),  32'(got.xe));
    check("timing_err", 32'(timing_err), 32'(got.te));
    check("fail_count", fail_count,      got.fc);
    step_no++;
  endtask

  initial begin
    resetn = 1'b0; init_done = 1'b0;
    {cs_n, ras_n, cas_n, we_n} = P_NOP;
    ba = 2'd0; addr = '0;

    //    rn id pins   ba a10 state     ce xe te       fc
    // Reset, init, then ACT b0 / NOP x3 / RD b0.
    step(0, 0, P_NOP, 0, 0, 16'h0000, 0, 0, 4'b0000, 0);
    step(1, 1, P_NOP, 0, 0, 16'h1111, 0, 0, 4'b0000, 0);
    step(1, 1, P_ACT, 0, 0, 16'h1113, 0, 0, 4'b0000, 0);
    step(1, 1, P_NOP, 0, 0, 16'h1113, 0, 0, 4'b0000, 0);
    step(1, 1, P_NOP, 0, 0, 16'h1113, 0, 0, 4'b0000, 0);
    step(1, 1, P_NOP, 0, 0, 16'h1114, 0, 0, 4'b0000, 0);
    step(1, 1, P_RD,  0, 0, 16'h1115, 0, 0, 4'b0000, 0);
    // ACT b1 then RD b1 inside tRCD: timing and same-bank error.
    step(1, 1, P_ACT, 1, 0, 16'h1135, 0, 0, 4'b0000, 0);
    step(1, 1, P_RD,  1, 0, 16'h1135, 1, 0, 4'b0010, 1);
    step(1, 1, P_NOP, 0, 0, 16'h1135, 0, 0, 4'b0000, 1);
    step(1, 1, P_NOP, 0, 0, 16'h1144, 0, 0, 4'b0000, 1);
    // PRE b0; a deselected ACT pattern while precharging is ignored.
    step(1, 1, P_PRE, 0, 0, 16'h1149, 0, 0, 4'b0000, 1);
    step(1, 1, P_DES, 0, 0, 16'h1149, 0, 0, 4'b0000, 1);
    step(1, 1, P_NOP, 0, 0, 16'h1141, 0, 0, 4'b0000, 1);
    // Bank0 activating, REF to b2: cross-bank error only.
    step(1, 1, P_ACT, 0, 0, 16'h1143, 0, 0, 4'b0000, 1);
    step(1, 1, P_REF, 2, 0, 16'h1243, 0, 1, 4'b0000, 1);
    step(1, 1, P_NOP, 0, 0, 16'h1143, 0, 0, 4'b0000, 1);
    step(1, 1, P_NOP, 0, 0, 16'h1144, 0, 0, 4'b0000, 1);
    // Bank2 precharging, ACT b2: same-bank error plus tRP.
    step(1, 1, P_ACT, 2, 0, 16'h1344, 0, 0, 4'b0000, 1);
    step(1, 1, P_NOP, 0, 0, 16'h1344, 0, 0, 4'b0000, 1);
    step(1, 1, P_NOP, 0, 0, 16'h1344, 0, 0, 4'b0000, 1);
    step(1, 1, P_NOP, 0, 0, 16'h1444, 0, 0, 4'b0000, 1);
    step(1, 1, P_PRE, 2, 0, 16'h1944, 0, 0, 4'b0000, 1);
    step(1, 1, P_ACT, 2, 0, 16'h1944, 1, 0, 4'b0100, 2);
    step(1, 1, P_NOP, 0, 0, 16'h1144, 0, 0, 4'b0000, 2);
    // RD b3 with auto-precharge: RD_W_PC x4, PRECHARGING x2, IDLE.
    step(1, 1, P_ACT, 3, 0, 16'h3144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h3144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h3144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h4144, 0, 0, 4'b0000, 2);
    step(1, 1, P_RD,  3, 1, 16'h6144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h6144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h6144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h6144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h9144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h9144, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h1144, 0, 0, 4'b0000, 2);
    // WR b0 then precharge-all next cycle: tWR violation.
    step(1, 1, P_WR,  0, 0, 16'h1147, 0, 0, 4'b0000, 2);
    step(1, 1, P_PRE, 0, 1, 16'h1199, 0, 0, 4'b1000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h1199, 0, 0, 4'b0000, 2);
    step(1, 1, P_NOP, 0, 0, 16'h1111, 0, 0, 4'b0000, 2);
    // Repeat ACT to an activating bank, then reset mid-operation.
    step(1, 1, P_ACT, 1, 0, 16'h1131, 0, 0, 4'b0000, 2);
    step(1, 1, P_ACT, 1, 0, 16'h1131, 1, 0, 4'b0000, 3);
    step(0, 1, P_ACT, 1, 0, 16'h0000, 0, 0, 4'b0000, 0);
    // Banks in INIT ignore commands until init_done.
    step(1, 0, P_RD,  0, 0, 16'h0000, 0, 0, 4'b0000, 0);
    step(1, 1, P_NOP, 0, 0, 16'h1111, 0, 0, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
